// File: rtl/jtag_pkg.sv
// jtag_pkg
// Shared types and constants for the JTAG-to-AXI bridge data-register bank:
//   tap_ctrl_fsm_t  - the 16 IEEE 1149.1 TAP controller states
//   ir_decoding_t   - instruction codes decoded by the IR decoder
//   s_axi_jtag_t    - AXI request fields {addr, data, mgmt} latched from JTAG
//   tdo_src_t       - which data register currently drives TDO
// plus helpers that load/shift only the low W bits of the shared shift register.
package jtag_pkg;

    localparam int ADDR_AXI_WIDTH = 32;
    localparam int DATA_AXI_WIDTH = 32;
    localparam int MGMT_WIDTH     = 8;
    localparam int IDCODE_WIDTH   = 32;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The shared shift register must hold the widest register that uses it.
    localparam int DR_MAX_WIDTH = max2(max2(ADDR_AXI_WIDTH, DATA_AXI_WIDTH),
                                       max2(MGMT_WIDTH, IDCODE_WIDTH));

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'h0,
        RUN_TEST_IDLE    = 4'h1,
        SELECT_DR_SCAN   = 4'h2,
        CAPTURE_DR       = 4'h3,
        SHIFT_DR         = 4'h4,
        EXIT1_DR         = 4'h5,
        PAUSE_DR         = 4'h6,
        EXIT2_DR         = 4'h7,
        UPDATE_DR        = 4'h8,
        SELECT_IR_SCAN   = 4'h9,
        CAPTURE_IR       = 4'hA,
        SHIFT_IR         = 4'hB,
        EXIT1_IR         = 4'hC,
        PAUSE_IR         = 4'hD,
        EXIT2_IR         = 4'hE,
        UPDATE_IR        = 4'hF
    } tap_ctrl_fsm_t;

    // Codes not listed here are legal inputs; they select no register.
    typedef enum logic [3:0] {
        IDCODE            = 4'h1,
        SAMPLE_PRELOAD    = 4'h2,
        IC_RESET          = 4'h3,
        ADDR_AXI_REGISTER = 4'h4,
        DATA_AXI_REGISTER = 4'h5,
        MGMT_AXI_REGISTER = 4'h6,
        BYPASS            = 4'hF
    } ir_decoding_t;

    typedef struct packed {
        logic [3:0] len;
        logic [2:0] size;
        logic       rnw;
    } s_axi_jtag_mgmt_fields_t;

    // Management word: field view for the AXI master, flat view for shifting.
    typedef union packed {
        s_axi_jtag_mgmt_fields_t  f;
        logic [MGMT_WIDTH-1:0]    flat;
    } s_axi_jtag_mgmt_t;

    typedef struct packed {
        logic [ADDR_AXI_WIDTH-1:0] addr;
        logic [DATA_AXI_WIDTH-1:0] data;
        s_axi_jtag_mgmt_t          mgmt;
    } s_axi_jtag_t;

    typedef enum logic [1:0] {
        TDO_NONE   = 2'd0,
        TDO_BYPASS = 2'd1,
        TDO_IDCODE = 2'd2,
        TDO_SR     = 2'd3
    } tdo_src_t;

    // Replace bits [w-1:0] of sr with v, leaving the upper bits alone.
    function automatic logic [DR_MAX_WIDTH-1:0] load_low(
        input logic [DR_MAX_WIDTH-1:0] sr,
        input int                      w,
        input logic [DR_MAX_WIDTH-1:0] v
    );
        logic [DR_MAX_WIDTH-1:0] r;
        r = sr;
        for (int i = 0; i < DR_MAX_WIDTH; i++) begin
            if (i < w) r[i] = v[i];
        end
        return r;
    endfunction

    // Shift bits [w-1:0] of sr right by one with b entering at bit w-1.
    function automatic logic [DR_MAX_WIDTH-1:0] shift_low(
        input logic [DR_MAX_WIDTH-1:0] sr,
        input int                      w,
        input logic                    b
    );
        logic [DR_MAX_WIDTH-1:0] r;
        r = sr;
        for (int i = 0; i < DR_MAX_WIDTH - 1; i++) begin
            if (i < w - 1) r[i] = sr[i + 1];
        end
        for (int i = 0; i < DR_MAX_WIDTH; i++) begin
            if (i == w - 1) r[i] = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/unique0_dr.sv
// unique0_dr
// JTAG data-register bank behind the TAP controller / IR decoder of the
// JTAG-to-AXI bridge: BYPASS, IDCODE, SAMPLE_PRELOAD, IC_RESET and the AXI
// address/data/management registers. Shifts TDI->TDO LSB-first in SHIFT_DR.
// Ports:
//   tck        JTAG clock (state on posedge, TDO source on negedge)
//   trstn      asynchronous active-low reset
//   tdi / tdo  serial data in / out
//   tap_state  current TAP controller state
//   ir_dec     decoded instruction
//   ic_rst     latched reset-selection value
//   axi_info   latched AXI addr/data/mgmt
//   axi_update one-tck strobe following a MGMT update
module unique0_dr
    import jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE_VAL   = 32'h0000_010F,
    parameter int          IC_RST_WIDTH = 4
) (
    input  logic                    tck,
    input  logic                    trstn,
    input  logic                    tdi,
    output logic                    tdo,
    input  tap_ctrl_fsm_t           tap_state,
    input  ir_decoding_t            ir_dec,
    output logic [IC_RST_WIDTH-1:0] ic_rst,
    output s_axi_jtag_t             axi_info,
    output logic                    axi_update
);

    if (IC_RST_WIDTH > DR_MAX_WIDTH || IC_RST_WIDTH < 1) begin : g_bad_ic_rst_width
        $error("unique0_dr: IC_RST_WIDTH must be between 1 and DR_MAX_WIDTH");
    end

    logic                    bypass_q,     bypass_d;
    logic [31:0]             idcode_q,     idcode_d;
    logic [DR_MAX_WIDTH-1:0] sr_q,         sr_d;
    logic [IC_RST_WIDTH-1:0] ic_rst_q,     ic_rst_d;
    s_axi_jtag_t             axi_q,        axi_d;
    logic                    axi_update_q, axi_update_d;
    tdo_src_t                tdo_sel_q,    tdo_sel_d;

    // Only bit 0 of each register ever reaches TDO, so only bit 0 is copied.
    logic bypass_neg_q;
    logic idcode_neg_q;
    logic sr_neg_q;

    always_comb begin
        bypass_d     = bypass_q;
        idcode_d     = idcode_q;
        sr_d         = sr_q;
        ic_rst_d     = ic_rst_q;
        axi_d        = axi_q;
        axi_update_d = 1'b0;
        case (ir_dec)
            BYPASS: begin
                if (tap_state == CAPTURE_DR)    bypass_d = 1'b0;
                else if (tap_state == SHIFT_DR) bypass_d = tdi;
            end
            IDCODE: begin
                if (tap_state == CAPTURE_DR)    idcode_d = IDCODE_VAL;
                else if (tap_state == SHIFT_DR) idcode_d = {tdi, idcode_q[31:1]};
            end
            SAMPLE_PRELOAD: begin
                if (tap_state == CAPTURE_DR)    sr_d = '0;
                else if (tap_state == SHIFT_DR) sr_d = {tdi, sr_q[DR_MAX_WIDTH-1:1]};
            end
            IC_RESET: begin
                if (tap_state == CAPTURE_DR)
                    sr_d = load_low(sr_q, IC_RST_WIDTH, DR_MAX_WIDTH'(ic_rst_q));
                else if (tap_state == SHIFT_DR)
                    sr_d = shift_low(sr_q, IC_RST_WIDTH, tdi);
                else if (tap_state == UPDATE_DR)
                    ic_rst_d = sr_q[IC_RST_WIDTH-1:0];
            end
            ADDR_AXI_REGISTER: begin
                if (tap_state == CAPTURE_DR)
                    sr_d = load_low(sr_q, ADDR_AXI_WIDTH, DR_MAX_WIDTH'(axi_q.addr));
                else if (tap_state == SHIFT_DR)
                    sr_d = shift_low(sr_q, ADDR_AXI_WIDTH, tdi);
                else if (tap_state == UPDATE_DR)
                    axi_d.addr = sr_q[ADDR_AXI_WIDTH-1:0];
            end
            DATA_AXI_REGISTER: begin
                if (tap_state == CAPTURE_DR)
                    sr_d = load_low(sr_q, DATA_AXI_WIDTH, DR_MAX_WIDTH'(axi_q.data));
                else if (tap_state == SHIFT_DR)
                    sr_d = shift_low(sr_q, DATA_AXI_WIDTH, tdi);
                else if (tap_state == UPDATE_DR)
                    axi_d.data = sr_q[DATA_AXI_WIDTH-1:0];
            end
            MGMT_AXI_REGISTER: begin
                if (tap_state == CAPTURE_DR)
                    sr_d = load_low(sr_q, MGMT_WIDTH, DR_MAX_WIDTH'(axi_q.mgmt.flat));
                else if (tap_state == SHIFT_DR)
                    sr_d = shift_low(sr_q, MGMT_WIDTH, tdi);
                else if (tap_state == UPDATE_DR) begin
                    axi_d.mgmt.flat = sr_q[MGMT_WIDTH-1:0];
                    axi_update_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // TDO source is chosen from the state/instruction of the current cycle and
    // latched on the falling edge together with the register bit it exposes.
    always_comb begin
        tdo_sel_d = TDO_NONE;
        if (tap_state == SHIFT_DR) begin
            case (ir_dec)
                BYPASS:            tdo_sel_d = TDO_BYPASS;
                IDCODE:            tdo_sel_d = TDO_IDCODE;
                SAMPLE_PRELOAD,
                IC_RESET,
                ADDR_AXI_REGISTER,
                DATA_AXI_REGISTER,
                MGMT_AXI_REGISTER: tdo_sel_d = TDO_SR;
                default:           tdo_sel_d = TDO_NONE;
            endcase
        end
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            bypass_q     <= 1'b0;
            idcode_q     <= '0;
            sr_q         <= '0;
            ic_rst_q     <= '0;
            axi_q        <= '0;
            axi_update_q <= 1'b0;
        end else begin
            bypass_q     <= bypass_d;
            idcode_q     <= idcode_d;
            sr_q         <= sr_d;
            ic_rst_q     <= ic_rst_d;
            axi_q        <= axi_d;
            axi_update_q <= axi_update_d;
        end
    end

    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            bypass_neg_q <= 1'b0;
            idcode_neg_q <= 1'b0;
            sr_neg_q     <= 1'b0;
            tdo_sel_q    <= TDO_NONE;
        end else begin
            bypass_neg_q <= bypass_q;
            idcode_neg_q <= idcode_q[0];
            sr_neg_q     <= sr_q[0];
            tdo_sel_q    <= tdo_sel_d;
        end
    end

    always_comb begin
        case (tdo_sel_q)
            TDO_BYPASS: tdo = bypass_neg_q;
            TDO_IDCODE: tdo = idcode_neg_q;
            TDO_SR:     tdo = sr_neg_q;
            default:    tdo = 1'b0;
        endcase
    end

    assign ic_rst     = ic_rst_q;
    assign axi_info   = axi_q;
    assign axi_update = axi_update_q;

endmodule

// File: tb/tb_unique0_dr.sv
// tb_unique0_dr
// Randomized and directed stimulus for unique0_dr, checked every cycle against
// a register-level behavioural model built from the data-register rules.
module tb_unique0_dr;
    import jtag_pkg::*;

    localparam logic [31:0] IDV = 32'h0000_010F;
    localparam int          ICW = 4;

    logic            tck = 1'b0;
    logic            trstn = 1'b0;
    logic            tdi = 1'b0;
    logic            tdo;
    tap_ctrl_fsm_t   tap_state = TEST_LOGIC_RESET;
    ir_decoding_t    ir_dec = BYPASS;
    logic [ICW-1:0]  ic_rst;
    s_axi_jtag_t     axi_info;
    logic            axi_update;

    int n_vec = 0;
    int n_err = 0;
    logic last_tdo;

    // Behavioural model state
    logic        m_byp;
    logic [31:0] m_idc;
    logic [31:0] m_sr;
    logic [3:0]  m_ic;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [7:0]  m_mgmt;
    logic        m_upd;

    unique0_dr #(.IDCODE_VAL(IDV), .IC_RST_WIDTH(ICW)) dut (
        .tck        (tck),
        .trstn      (trstn),
        .tdi        (tdi),
        .tdo        (tdo),
        .tap_state  (tap_state),
        .ir_dec     (ir_dec),
        .ic_rst     (ic_rst),
        .axi_info   (axi_info),
        .axi_update (axi_update)
    );

    always #5 tck = ~tck;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] sr, input int w, input logic [31:0] v);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return 32'(({32'd0, sr} & ~mask) | ({32'd0, v} & mask));
    endfunction

    function automatic logic [31:0] m_shift(input logic [31:0] sr, input int w, input logic b);
        logic [63:0] mask;
        logic [63:0] low;
        mask = (64'd1 << w) - 64'd1;
        low  = (({32'd0, sr} & mask) >> 1) | (64'(b) << (w - 1));
        return 32'(({32'd0, sr} & ~mask) | low);
    endfunction

    task automatic model_reset();
        m_byp = 0; m_idc = 0; m_sr = 0; m_ic = 0;
        m_addr = 0; m_data = 0; m_mgmt = 0; m_upd = 0;
    endtask

    function automatic logic model_tdo(input tap_ctrl_fsm_t st, input ir_decoding_t ir);
        if (st != SHIFT_DR) return 1'b0;
        case (ir)
            BYPASS:            return m_byp;
            IDCODE:            return m_idc[0];
            SAMPLE_PRELOAD,
            IC_RESET,
            ADDR_AXI_REGISTER,
            DATA_AXI_REGISTER,
            MGMT_AXI_REGISTER: return m_sr[0];
            default:           return 1'b0;
        endcase
    endfunction

    task automatic model_clock(input tap_ctrl_fsm_t st, input ir_decoding_t ir, input logic b);
        m_upd = 0;
        case (ir)
            BYPASS: begin
                if (st == CAPTURE_DR) m_byp = 0;
                else if (st == SHIFT_DR) m_byp = b;
            end
            IDCODE: begin
                if (st == CAPTURE_DR) m_idc = IDV;
                else if (st == SHIFT_DR) m_idc = (m_idc >> 1) | (32'(b) << 31);
            end
            SAMPLE_PRELOAD: begin
                if (st == CAPTURE_DR) m_sr = 0;
                else if (st == SHIFT_DR) m_sr = (m_sr >> 1) | (32'(b) << 31);
            end
            IC_RESET: begin
                if (st == CAPTURE_DR) m_sr = m_load(m_sr, ICW, 32'(m_ic));
                else if (st == SHIFT_DR) m_sr = m_shift(m_sr, ICW, b);
                else if (st == UPDATE_DR) m_ic = m_sr[3:0];
            end
            ADDR_AXI_REGISTER: begin
                if (st == CAPTURE_DR) m_sr = m_addr;
                else if (st == SHIFT_DR) m_sr = m_shift(m_sr, 32, b);
                else if (st == UPDATE_DR) m_addr = m_sr;
            end
            DATA_AXI_REGISTER: begin
                if (st == CAPTURE_DR) m_sr = m_data;
                else if (st == SHIFT_DR) m_sr = m_shift(m_sr, 32, b);
                else if (st == UPDATE_DR) m_data = m_sr;
            end
            MGMT_AXI_REGISTER: begin
                if (st == CAPTURE_DR) m_sr = m_load(m_sr, 8, 32'(m_mgmt));
                else if (st == SHIFT_DR) m_sr = m_shift(m_sr, 8, b);
                else if (st == UPDATE_DR) begin
                    m_mgmt = m_sr[7:0];
                    m_upd  = 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_regs();
        checkOutput("ic_rst", 64'(ic_rst), 64'(m_ic));
        checkOutput("axi_addr", 64'(axi_info.addr), 64'(m_addr));
        checkOutput("axi_data", 64'(axi_info.data), 64'(m_data));
        checkOutput("axi_mgmt", 64'(axi_info.mgmt.flat), 64'(m_mgmt));
        checkOutput("axi_update", 64'(axi_update), 64'(m_upd));
    endtask

    // One tck cycle: called #1 after a posedge, returns #1 after the next one.
    task automatic applyStimulus(input tap_ctrl_fsm_t st, input ir_decoding_t ir, input logic b);
        tap_state = st;
        ir_dec    = ir;
        tdi       = b;
        @(negedge tck);
        #1;
        checkOutput("tdo", 64'(tdo), 64'(model_tdo(st, ir)));
        last_tdo = tdo;
        @(posedge tck);
        model_clock(st, ir, b);
        #1;
        check_regs();
    endtask

    task automatic shift_word(input ir_decoding_t ir, input logic [31:0] din, input int n,
                              output logic [31:0] dout);
        dout = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(SHIFT_DR, ir, din[i]);
            dout[i] = last_tdo;
        end
    endtask

    task automatic write_reg(input ir_decoding_t ir, input logic [31:0] din, input int n);
        logic [31:0] unused_out;
        applyStimulus(CAPTURE_DR, ir, 1'b0);
        shift_word(ir, din, n, unused_out);
        applyStimulus(UPDATE_DR, ir, 1'b0);
    endtask

    task automatic read_reg(input ir_decoding_t ir, input int n, output logic [31:0] dout);
        applyStimulus(CAPTURE_DR, ir, 1'b0);
        shift_word(ir, 32'd0, n, dout);
    endtask

    task automatic pulse_reset();
        trstn = 1'b0;
        #1;
        model_reset();
        checkOutput("rst_ic_rst", 64'(ic_rst), 64'd0);
        checkOutput("rst_axi_info", 64'(axi_info.addr) | 64'(axi_info.data) | 64'(axi_info.mgmt.flat), 64'd0);
        checkOutput("rst_axi_update", 64'(axi_update), 64'd0);
        checkOutput("rst_tdo", 64'(tdo), 64'd0);
        tap_state = TEST_LOGIC_RESET;
        ir_dec    = BYPASS;
        tdi       = 1'b0;
        @(negedge tck);
        #1;
        trstn = 1'b1;
        @(posedge tck);
        #1;
    endtask

    function automatic tap_ctrl_fsm_t rand_state();
        int r;
        r = $urandom_range(0, 15);
        if (r < 4)  return CAPTURE_DR;
        if (r < 12) return SHIFT_DR;
        if (r < 14) return UPDATE_DR;
        return tap_ctrl_fsm_t'(4'($urandom_range(0, 15)));
    endfunction

    function automatic ir_decoding_t rand_ir();
        logic [3:0] codes [9];
        codes = '{4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h0};
        return ir_decoding_t'(codes[$urandom_range(0, 8)]);
    endfunction

    initial begin
        logic [31:0] w;
        model_reset();
        @(posedge tck);
        #1;
        pulse_reset();

        // IDCODE stream
        read_reg(IDCODE, 32, w);
        checkOutput("idcode_stream", 64'(w), 64'h0000_010F);

        // BYPASS: tdi 1,0,1,1 -> tdo 0,1,0,1
        applyStimulus(CAPTURE_DR, BYPASS, 1'b0);
        shift_word(BYPASS, 32'b1101, 4, w);
        checkOutput("bypass_stream", 64'(w[3:0]), 64'hA);

        // IC_RESET write and readback
        write_reg(IC_RESET, 32'hA, 4);
        checkOutput("ic_rst_lit", 64'(ic_rst), 64'hA);
        read_reg(IC_RESET, 4, w);
        checkOutput("ic_rst_readback", 64'(w[3:0]), 64'hA);

        // Upper sr bits survive a narrow capture
        applyStimulus(CAPTURE_DR, SAMPLE_PRELOAD, 1'b0);
        shift_word(SAMPLE_PRELOAD, 32'hCAFE_F00D, 32, w);
        applyStimulus(CAPTURE_DR, IC_RESET, 1'b0);
        shift_word(SAMPLE_PRELOAD, 32'd0, 32, w);
        checkOutput("sr_upper_kept", 64'(w), 64'hCAFE_F00A);

        // AXI address / data
        write_reg(ADDR_AXI_REGISTER, 32'hDEAD_BEEF, 32);
        write_reg(DATA_AXI_REGISTER, 32'h1234_5678, 32);
        checkOutput("addr_lit", 64'(axi_info.addr), 64'hDEAD_BEEF);
        checkOutput("data_lit", 64'(axi_info.data), 64'h1234_5678);
        read_reg(ADDR_AXI_REGISTER, 32, w);
        checkOutput("addr_readback", 64'(w), 64'hDEAD_BEEF);
        read_reg(DATA_AXI_REGISTER, 32, w);
        checkOutput("data_readback", 64'(w), 64'h1234_5678);

        // MGMT update strobe
        write_reg(MGMT_AXI_REGISTER, 32'h5A, 8);
        checkOutput("mgmt_lit", 64'(axi_info.mgmt.flat), 64'h5A);
        checkOutput("update_pulse_hi", 64'(axi_update), 64'd1);
        applyStimulus(RUN_TEST_IDLE, MGMT_AXI_REGISTER, 1'b1);
        checkOutput("update_pulse_lo", 64'(axi_update), 64'd0);
        checkOutput("idle_tdo_zero", 64'(last_tdo), 64'd0);

        // Reset in the middle of an IDCODE shift
        applyStimulus(CAPTURE_DR, IDCODE, 1'b0);
        applyStimulus(SHIFT_DR, IDCODE, 1'b0);
        applyStimulus(SHIFT_DR, IDCODE, 1'b0);
        pulse_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) pulse_reset();
            applyStimulus(rand_state(), rand_ir(), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
